// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial sequence-detector scheduler.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_ptr names the requester preferred on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = rr_ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other requester becomes preferred.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (upd && (win != 2'b00)) begin
      rr_ptr_d = win[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Shares one serial Moore detector between two word requesters: arbitrate, clear,
// shift the word MSB first, count det_out samples and report the count with the id.
//
//  state    | meaning
//  ST_IDLE  | detector held in reset, waiting for a request
//  ST_CLR   | grant pulse, detector still in reset, count cleared
//  ST_SHIFT | one word bit per cycle on det_in, MSB first
//  ST_DRAIN | det_in low, collects the sample for the last bit
//  ST_DONE  | done pulse with match_cnt/done_id
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             det_reset,
  output logic             det_in,
  input  logic             det_out,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("seq_detect_sched: WIDTH must be at least 2");
  end
  if (clog2(WIDTH + 1) > CNT_W) begin : g_cnt_chk
    $error("seq_detect_sched: CNT_W too narrow to hold WIDTH matches");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             id_q, id_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             det_reset_q, det_reset_d;
  logic             det_in_q, det_in_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic       arb_upd;
  logic [1:0] arb_win;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .upd     (arb_upd),
    .win     (arb_win)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    id_d    = id_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    arb_upd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          arb_upd = 1'b1;
          id_d    = arb_win[1];
          shreg_d = arb_win[1] ? data1 : data0;
          cnt_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        idx_d   = IDX_LAST;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The first shift cycle sees only the cleared detector, so it is not sampled.
        if ((idx_q != IDX_LAST) && det_out) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (idx_q == '0) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DRAIN: begin
        if (det_out) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_SHIFT) begin
      shreg_d = shreg_q << 1;
    end

    gnt_d       = arb_upd ? arb_win : 2'b00;
    busy_d      = (state_d != ST_IDLE);
    det_reset_d = (state_d == ST_IDLE) || (state_d == ST_CLR);
    det_in_d    = (state_d == ST_SHIFT) && shreg_q[WIDTH-1];
    done_d      = (state_d == ST_DONE);
    match_cnt_d = done_d ? cnt_d : match_cnt_q;
    done_id_d   = done_d ? id_q : done_id_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      id_q        <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
      det_reset_q <= 1'b1;
      det_in_q    <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      det_reset_q <= det_reset_d;
      det_in_q    <= det_in_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign det_reset = det_reset_q;
  assign det_in    = det_in_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule
